// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive-side capture with geometry check and lock-gated write stream
//
// Purpose:
//   Registers an incoming pixel-clock video stream, measures each frame's
//   geometry between vsync edges, and builds lock over LOCK_FRAMES good
//   frames. Once locked, whole frames are forwarded as a write stream with
//   start-of-frame and end-of-line markers. Frames that start unlocked are
//   never written, so partial or malformed frames cannot reach memory.
//
// Ports:
//   clk        pixel clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   hsync_in   line sync (registered only; geometry is measured from de)
//   vsync_in   frame sync, active-high
//   de_in      data enable, high for active pixels
//   rgb_in     24-bit pixel data
//   wr_en      write strobe, one pixel per cycle
//   wr_data    pixel written when wr_en=1
//   sof        marks pixel (0,0) of a captured frame
//   eol        marks the last pixel of each captured line
//   pix_x      x coordinate of wr_data
//   pix_y      y coordinate of wr_data
//   locked     geometry verified over LOCK_FRAMES consecutive frames
//   frame_err  one-cycle pulse when a frame fails the geometry check
//   frame_cnt  completed frame counter, wraps at 256

module vga_capture #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 960,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [23:0] rgb_in,
    output logic        wr_en,
    output logic [23:0] wr_data,
    output logic        sof,
    output logic        eol,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        locked,
    output logic        frame_err,
    output logic [7:0]  frame_cnt
);

    localparam logic [10:0] H11     = 11'(H_ACTIVE);
    localparam logic [10:0] V11     = 11'(V_ACTIVE);
    localparam logic [11:0] H12     = 12'(H_ACTIVE);
    localparam logic [3:0]  LOCK4   = 4'(LOCK_FRAMES);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    typedef enum logic {
        S_SEEK,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_hs_d;
    logic        r_vs_d;
    logic        r_de_d;
    logic [23:0] r_rgb_d;

    logic [10:0] r_x_cnt;
    logic [10:0] r_y_cnt;
    logic        r_line_bad;
    logic [3:0]  r_good_cnt;
    logic        r_cap_gate;

    logic [10:0] w_x_nxt;
    logic [10:0] w_y_nxt;
    logic        w_line_bad_nxt;
    logic        w_frame_end;
    logic        w_frame_bad;
    logic [3:0]  w_good_inc;

    logic        w_vs_fall;
    logic        w_vs_rise;
    logic        w_de_fall;
    logic        w_q;

    // hsync is carried through stage 1 for symmetry but geometry is
    // measured from de transitions alone.
    logic        w_unused_hs;
    assign w_unused_hs = r_hs_d;

    // Edges compare the stage-1 copy with the raw input so the last pixel
    // of a line (still in de_d) is seen together with its de_fall.
    assign w_vs_fall = r_vs_d & ~vsync_in;
    assign w_vs_rise = ~r_vs_d & vsync_in;
    assign w_de_fall = r_de_d & ~de_in;

    assign w_q = r_de_d & r_cap_gate & (r_state == S_RUN) &
                 (r_x_cnt < H11) & (r_y_cnt < V11);

    assign w_good_inc = (r_good_cnt == LOCK4) ? r_good_cnt : r_good_cnt + 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x_cnt;
        w_y_nxt        = r_y_cnt;
        w_line_bad_nxt = r_line_bad;
        w_frame_end    = 1'b0;
        w_frame_bad    = 1'b0;
        case (r_state)
            S_SEEK: begin
                if (w_vs_fall) begin
                    w_state_nxt    = S_RUN;
                    w_x_nxt        = '0;
                    w_y_nxt        = '0;
                    w_line_bad_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (r_de_d) begin
                    if (w_de_fall) begin
                        if (({1'b0, r_x_cnt} + 12'd1) != H12) begin
                            w_line_bad_nxt = 1'b1;
                        end
                        if (r_y_cnt != CNT_MAX) begin
                            w_y_nxt = r_y_cnt + 11'd1;
                        end
                        w_x_nxt = '0;
                    end else if (r_x_cnt != CNT_MAX) begin
                        w_x_nxt = r_x_cnt + 11'd1;
                    end
                end
                // The frame check sees any line closed on this same cycle.
                if (w_vs_rise) begin
                    w_frame_end = 1'b1;
                    w_frame_bad = w_line_bad_nxt | (w_y_nxt != V11);
                end
                if (w_vs_fall) begin
                    w_x_nxt        = '0;
                    w_y_nxt        = '0;
                    w_line_bad_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_SEEK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_SEEK;
            r_hs_d     <= 1'b0;
            r_vs_d     <= 1'b0;
            r_de_d     <= 1'b0;
            r_rgb_d    <= '0;
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_line_bad <= 1'b0;
            r_good_cnt <= '0;
            r_cap_gate <= 1'b0;
            locked     <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hs_d     <= hsync_in;
            r_vs_d     <= vsync_in;
            r_de_d     <= de_in;
            r_rgb_d    <= rgb_in;
            r_x_cnt    <= w_x_nxt;
            r_y_cnt    <= w_y_nxt;
            r_line_bad <= w_line_bad_nxt;

            frame_err <= w_frame_end & w_frame_bad;
            if (w_frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (w_frame_bad) begin
                    r_good_cnt <= '0;
                    locked     <= 1'b0;
                end else begin
                    r_good_cnt <= w_good_inc;
                    if (w_good_inc == LOCK4) begin
                        locked <= 1'b1;
                    end
                end
            end

            // Capture decision is frozen for the whole frame at its start.
            if (w_vs_fall) begin
                r_cap_gate <= locked;
            end

            wr_en   <= w_q;
            wr_data <= r_rgb_d;
            pix_x   <= r_x_cnt;
            pix_y   <= r_y_cnt;
            sof     <= w_q & (r_x_cnt == 11'd0) & (r_y_cnt == 11'd0);
            eol     <= w_q & w_de_fall;
        end
    end

endmodule
